// File: rtl/dpe_wg_pkg.sv
// rtl/dpe_wg_pkg.sv - WireGuard transport header constants, FSM states and header record
// Shared by dpe_wg_rx_deframer and dpe_wg_replay_win.
package dpe_wg_pkg;

  localparam logic [7:0]  WG_MSG_TRANSPORT = 8'd4;
  localparam int          WG_HDR_BEATS     = 2;
  localparam logic [63:0] WG_REJECT_AFTER  = 64'hFFFF_FFFF_FFFF_E000;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_CHECK,
    ST_PASS,
    ST_DROP
  } wg_state_t;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [23:0] rsvd;
    logic [31:0] idx;
    logic [63:0] ctr;
  } wg_hdr_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dpe_wg_replay_win.sv
// rtl/dpe_wg_replay_win.sv - anti-replay sliding window: combinational verdict, registered state
// Bit k of bitmap records that counter (max_ctr - k) has already been accepted.
module dpe_wg_replay_win
  import dpe_wg_pkg::*;
#(
  parameter int WIN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [63:0] ctr,
  output logic        accept
);

  localparam int IW = $clog2(WIN);

  logic [63:0]    max_ctr;
  logic [WIN-1:0] bitmap;
  logic           seen_any;
  logic [63:0]    fwd;
  logic [63:0]    back;

  assign fwd  = ctr - max_ctr;
  assign back = max_ctr - ctr;

  always_comb begin
    accept = 1'b0;
    if (ctr >= WG_REJECT_AFTER)
      accept = 1'b0;
    else if (!seen_any)
      accept = 1'b1;
    else if (ctr > max_ctr)
      accept = 1'b1;
    else if (back < 64'(WIN))
      accept = !bitmap[back[IW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_ctr  <= '0;
      bitmap   <= '0;
      seen_any <= 1'b0;
    end else if (upd && accept) begin
      seen_any <= 1'b1;
      if (!seen_any) begin
        max_ctr <= ctr;
        bitmap  <= WIN'(1);
      end else if (ctr > max_ctr) begin
        max_ctr <= ctr;
        // A jump of a full window or more leaves no older history worth keeping
        if (fwd >= 64'(WIN))
          bitmap <= WIN'(1);
        else
          bitmap <= (bitmap << fwd[IW-1:0]) | WIN'(1);
      end else begin
        bitmap[back[IW-1:0]] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpe_wg_rx_deframer.sv
// rtl/dpe_wg_rx_deframer.sv - WireGuard transport header strip, checks and anti-replay filter
// Replay filtering is built only when WG_REPLAY_CHECK_EN is defined.
module dpe_wg_rx_deframer
  import dpe_wg_pkg::*;
#(
  parameter int REPLAY_WIN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_local_idx,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic [63:0] out_ctr,
  output logic        out_ctr_vld,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_drop_hdr,
  output logic [31:0] stat_drop_idx,
  output logic [31:0] stat_drop_replay
);

  wg_state_t   state;
  wg_hdr_t     hdr;
  logic        first_beat;
  logic [63:0] ctr_q;
  logic        hdr_ok;
  logic        idx_ok;
  logic        pass;

  assign hdr_ok = (hdr.msg_type == WG_MSG_TRANSPORT) && (hdr.rsvd == 24'd0);
  assign idx_ok = (hdr.idx == cfg_local_idx);
  assign pass   = (state == ST_PASS);

`ifdef WG_REPLAY_CHECK_EN
  logic replay_ok;

  dpe_wg_replay_win #(.WIN(REPLAY_WIN)) u_replay (
    .clk    (clk),
    .rst    (rst),
    .upd    ((state == ST_CHECK) && hdr_ok && idx_ok),
    .ctr    (hdr.ctr),
    .accept (replay_ok)
  );
`else
  logic unused_win;
  assign unused_win       = (REPLAY_WIN == 64);
  assign stat_drop_replay = '0;
`endif

  // Payload is a zero-latency pass-through; everything is gated to zero outside PASS
  assign in_ready    = !rst && ((state == ST_HDR0) || (state == ST_HDR1) ||
                                (state == ST_DROP) || (pass && out_ready));
  assign out_valid   = pass && in_valid;
  assign out_data    = pass ? in_data : '0;
  assign out_keep    = pass ? in_keep : '0;
  assign out_sop     = pass && first_beat;
  assign out_eop     = pass && in_eop;
  assign out_ctr     = ctr_q;
  assign out_ctr_vld = pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_HDR0;
      hdr              <= '0;
      first_beat       <= 1'b0;
      ctr_q            <= '0;
      stat_ok          <= '0;
      stat_drop_hdr    <= '0;
      stat_drop_idx    <= '0;
`ifdef WG_REPLAY_CHECK_EN
      stat_drop_replay <= '0;
`endif
    end else begin
      case (state)
        ST_HDR0: begin
          if (in_valid && in_sop) begin
            hdr.msg_type <= in_data[7:0];
            hdr.rsvd     <= in_data[31:8];
            hdr.idx      <= in_data[63:32];
            if (in_eop)
              stat_drop_hdr <= sat_inc(stat_drop_hdr);
            else
              state <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (in_valid) begin
            hdr.ctr <= in_data;
            if (in_eop) begin
              stat_drop_hdr <= sat_inc(stat_drop_hdr);
              state         <= ST_HDR0;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (!hdr_ok) begin
            stat_drop_hdr <= sat_inc(stat_drop_hdr);
            state         <= ST_DROP;
          end else if (!idx_ok) begin
            stat_drop_idx <= sat_inc(stat_drop_idx);
            state         <= ST_DROP;
`ifdef WG_REPLAY_CHECK_EN
          end else if (!replay_ok) begin
            stat_drop_replay <= sat_inc(stat_drop_replay);
            state            <= ST_DROP;
`endif
          end else begin
            stat_ok    <= sat_inc(stat_ok);
            ctr_q      <= hdr.ctr;
            first_beat <= 1'b1;
            state      <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (in_valid && out_ready) begin
            first_beat <= 1'b0;
            if (in_eop)
              state <= ST_HDR0;
          end
        end
        ST_DROP: begin
          if (in_valid && in_eop)
            state <= ST_HDR0;
        end
        default: state <= ST_HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_dpe_wg_rx_deframer.sv
// tb/tb_dpe_wg_rx_deframer.sv - vector-table bench for dpe_wg_rx_deframer
// Expectations follow WG_REPLAY_CHECK_EN: with it undefined, every replay verdict becomes accept.
module tb_dpe_wg_rx_deframer;

  localparam logic [31:0] LOC = 32'h1122_3344;
`ifdef WG_REPLAY_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int R_OK = 0, R_HDR = 1, R_IDX = 2, R_RPL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_local_idx = LOC;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_sop, out_eop;
  logic [63:0] out_ctr;
  logic        out_ctr_vld;
  logic [31:0] stat_ok, stat_drop_hdr, stat_drop_idx, stat_drop_replay;

  dpe_wg_rx_deframer #(.REPLAY_WIN(64)) dut (
    .clk(clk), .rst(rst), .cfg_local_idx(cfg_local_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_sop(out_sop), .out_eop(out_eop), .out_ctr(out_ctr), .out_ctr_vld(out_ctr_vld),
    .stat_ok(stat_ok), .stat_drop_hdr(stat_drop_hdr), .stat_drop_idx(stat_drop_idx),
    .stat_drop_replay(stat_drop_replay)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          mon_beats, mon_sops, mon_eops, mon_sop_pos, viol;
  logic [63:0] mon_ctr;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  bit          bp_en = 1'b0;

  typedef struct {
    logic [7:0]  typ;
    logic [23:0] rsvd;
    logic [31:0] idx;
    logic [63:0] ctr;
    int          nb;
    int          res;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    mon_beats = 0; mon_sops = 0; mon_eops = 0; mon_sop_pos = -1; mon_ctr = '1;
  endtask

  task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e);
    bit done = 1'b0;
    in_data = d; in_keep = k; in_sop = s; in_eop = e; in_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("handshake_timeout", 64'd1, 64'd0);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] typ, input logic [23:0] rsvd, input logic [31:0] idx,
                          input logic [63:0] ctr, input int nb, input logic [7:0] lastk,
                          input bit exp_ok);
    logic [63:0] d;
    logic [7:0]  k;
    put_beat({idx, rsvd, typ}, 8'hFF, 1'b1, 1'b0);
    put_beat(ctr, 8'hFF, 1'b0, nb == 0);
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      k = (b == nb - 1) ? lastk : 8'hFF;
      if (exp_ok)
        for (int j = 0; j < 8; j++) if (k[j]) exp_q.push_back(d[8*j +: 8]);
      put_beat(d, k, 1'b0, b == nb - 1);
    end
  endtask

  // Output monitor and backpressure rule, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (out_sop) begin
        mon_sops++; mon_sop_pos = mon_beats; mon_ctr = out_ctr;
      end
      if (out_eop) mon_eops++;
      mon_beats++;
      for (int j = 0; j < 8; j++) if (out_keep[j]) got_q.push_back(out_data[8*j +: 8]);
    end
    if (out_ctr_vld && !out_ready && in_ready) viol++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e_ok, e_hdr, e_idx, e_rpl, eff, nb, n, mism, eops0;
    logic [7:0] lk;

    vt[0]  = '{8'd4, 24'd0,      LOC,          64'd5,   6, R_OK};
    vt[1]  = '{8'd1, 24'd0,      LOC,          64'd7,   3, R_HDR};
    vt[2]  = '{8'd4, 24'd0,      32'hDEADBEEF, 64'd6,   2, R_IDX};
    vt[3]  = '{8'd4, 24'h000100, LOC,          64'd8,   2, R_HDR};
    vt[4]  = '{8'd4, 24'd0,      LOC,          64'd10,  3, R_OK};
    vt[5]  = '{8'd4, 24'd0,      LOC,          64'd8,   2, R_OK};
    vt[6]  = '{8'd4, 24'd0,      LOC,          64'd10,  2, R_RPL};
    vt[7]  = '{8'd4, 24'd0,      LOC,          64'd74,  4, R_OK};
    vt[8]  = '{8'd4, 24'd0,      LOC,          64'd10,  1, R_RPL};
    vt[9]  = '{8'd4, 24'd0,      LOC,          64'd11,  1, R_OK};
    vt[10] = '{8'd4, 24'd0,      LOC,          64'd11,  1, R_RPL};
    vt[11] = '{8'd4, 24'd0,      LOC,          64'd100, 0, R_HDR};
    vt[12] = '{8'd2, 24'd0,      32'hDEADBEEF, 64'd101, 1, R_HDR};
    vt[13] = '{8'd4, 24'd0,      32'hDEADBEEF, 64'hFFFF_FFFF_FFFF_E000, 1, R_IDX};
    vt[14] = '{8'd4, 24'd0,      LOC,          64'hFFFF_FFFF_FFFF_E000, 2, R_RPL};
    vt[15] = '{8'd4, 24'd0,      LOC,          64'hFFFF_FFFF_FFFF_DFFF, 2, R_OK};
    vt[16] = '{8'd4, 24'd0,      LOC,          64'd100, 1, R_RPL};

    viol = 0;
    clr_mon();
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctr_vld", out_ctr_vld, 0);
    chk("rst_stat_ok", stat_ok, 0);
    chk("rst_stat_drop_hdr", stat_drop_hdr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    e_ok = 0; e_hdr = 0; e_idx = 0; e_rpl = 0;
    for (int i = 0; i < 17; i++) begin
      eff = (vt[i].res == R_RPL && !RC) ? R_OK : vt[i].res;
      case (eff)
        R_OK:    e_ok++;
        R_HDR:   e_hdr++;
        R_IDX:   e_idx++;
        default: e_rpl++;
      endcase
      clr_mon();
      send_pkt(vt[i].typ, vt[i].rsvd, vt[i].idx, vt[i].ctr, vt[i].nb, 8'h0F, eff == R_OK);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_beats", i), mon_beats, (eff == R_OK) ? vt[i].nb : 0);
      chk($sformatf("vec%0d_eops", i), mon_eops, (eff == R_OK) ? 1 : 0);
      if (eff == R_OK) begin
        chk($sformatf("vec%0d_ctr", i), mon_ctr, vt[i].ctr);
        chk($sformatf("vec%0d_sop_pos", i), mon_sop_pos, 0);
      end
    end
    chk("tbl_stat_ok", stat_ok, e_ok);
    chk("tbl_stat_drop_hdr", stat_drop_hdr, e_hdr);
    chk("tbl_stat_drop_idx", stat_drop_idx, e_idx);
    chk("tbl_stat_drop_replay", stat_drop_replay, e_rpl);

    // eop on the very first beat
    put_beat({LOC, 24'd0, 8'd4}, 8'hFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("eop_hdr0_drop_hdr", stat_drop_hdr, e_hdr + 1);

    // reset during payload beat 3 of 5
    clr_mon();
    put_beat({LOC, 24'd0, 8'd4}, 8'hFF, 1'b1, 1'b0);
    put_beat(64'hFFFF_FFFF_FFFF_DFF0, 8'hFF, 1'b0, 1'b0);
    put_beat(64'h1111, 8'hFF, 1'b0, 1'b0);
    put_beat(64'h2222, 8'hFF, 1'b0, 1'b0);
    in_data = 64'hA5A5_A5A5_A5A5_A5A5; in_keep = 8'hFF; in_valid = 1'b1;
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_ctr", {out_ctr_vld, out_sop, out_eop, out_keep}, 0);
    chk("arst_out_ctr_val", out_ctr, 0);
    chk("arst_stat_ok", stat_ok, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    put_beat(64'h4444, 8'hFF, 1'b0, 1'b0);
    put_beat(64'h5555, 8'h3F, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("abort_beats", mon_beats, 2);
    chk("abort_eops", mon_eops, 0);
    clr_mon();
    send_pkt(8'd4, 24'd0, LOC, 64'd0, 2, 8'hFF, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_ctr0_beats", mon_beats, 2);
    chk("post_rst_ctr0_ctr", mon_ctr, 0);
    chk("post_rst_stat_ok", stat_ok, 1);
    chk("post_rst_stat_drop_replay", stat_drop_replay, 0);

    // 100 packets under 30% output backpressure
    got_q.delete(); exp_q.delete();
    viol = 0; eops0 = mon_eops;
    bp_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      nb = $urandom_range(1, 5);
      n  = $urandom_range(1, 8);
      lk = 8'((1 << n) - 1);
      send_pkt(8'd4, 24'd0, LOC, 64'(1000 + i), nb, lk, 1'b1);
    end
    bp_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk("bp_byte_count", got_q.size(), exp_q.size());
    chk("bp_byte_mismatches", mism, 0);
    chk("bp_in_ready_while_stalled", viol, 0);
    chk("bp_eops", mon_eops - eops0, 100);
    chk("bp_stat_ok", stat_ok, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
